// File: rtl/ahb_can_pkg.sv
// Shared constants for the AHB-Lite to CAN mailbox front end.
// Holds the register offsets, the CTRL/STATUS/DONE bit positions and the AHB encodings.
// Also holds the TX arbiter state type.
package ahb_can_pkg;

  // Register byte offsets in the low 8 address bits
  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h04;
  localparam logic [7:0] ADDR_RXDATA  = 8'h08;
  localparam logic [7:0] ADDR_DONE    = 8'h0C;
  localparam logic [7:0] ADDR_MB_BASE = 8'h10;

  // CTRL bit positions
  localparam int CTRL_TX_EN     = 0;
  localparam int CTRL_RX_IRQ_EN = 1;
  localparam int CTRL_TX_IRQ_EN = 2;
  localparam int CTRL_W         = 3;

  // STATUS bit positions
  localparam int ST_RX_EMPTY     = 16;
  localparam int ST_RX_FULL      = 17;
  localparam int ST_RX_OVF       = 18;
  localparam int ST_RX_COUNT_LSB = 24;

  // DONE bit that clears the sticky RX overflow flag
  localparam int DONE_RX_OVF_CLR = 31;

  // AHB transfer types and the only legal transfer size
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [0:0] {
    TX_IDLE  = 1'b0,
    TX_OFFER = 1'b1
  } tx_state_t;

  // Word index of a byte offset
  function automatic logic [5:0] word_of(input logic [7:0] byte_addr);
    return byte_addr[7:2];
  endfunction

endpackage

// File: rtl/can_rx_fifo.sv
// Purpose: synchronous receive FIFO with occupancy count and a sticky overflow flag.
// Latency: a pushed frame is visible at dout the cycle after the push; dout shows the head combinationally.
// Backpressure: none on the push side; a push while full with no pop is dropped and sets ovf.
module can_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  input  logic                     ovf_clr,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push = push & (~full | do_pop);

  // Pointer advance and sticky overflow; a new overflow outranks a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && !do_push) ovf <= 1'b1;
      else if (ovf_clr)     ovf <= 1'b0;
    end
  end

  // Frame storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ahb_can_mailbox.sv
// Purpose: AHB-Lite register front end with TX mailboxes, round-robin TX arbiter and RX FIFO.
// Latency: zero-wait OKAY transfers; a TX offer is registered one cycle after a mailbox becomes eligible.
// Backpressure: offers hold until tx_ready; RX has none (overflow drops); bad accesses get a 2-cycle ERROR.
module ahb_can_mailbox
  import ahb_can_pkg::*;
#(
  parameter int NUM_TX_MB = 4,
  parameter int RX_DEPTH  = 8,
  parameter int FRAME_W   = 32
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               HSEL,
  input  logic [7:0]         HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  output logic [31:0]        HRDATA,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic               tx_valid,
  output logic [FRAME_W-1:0] tx_data,
  input  logic               tx_ready,
  input  logic               rx_valid,
  input  logic [FRAME_W-1:0] rx_data,
  output logic               irq
);

  localparam int MB_IDX_W = (NUM_TX_MB > 1) ? $clog2(NUM_TX_MB) : 1;
  localparam int CNT_W    = $clog2(RX_DEPTH) + 1;

  // ---------------- AHB address/data phase tracking ----------------
  logic       addr_acc;
  logic       dp_vld;
  logic       dp_write;
  logic       dp_size_ok;
  logic       dp_align_ok;
  logic [5:0] dp_word;
  logic       err_ph2;

  logic                sel_ctrl, sel_status, sel_rxdata, sel_done, sel_mb;
  logic [5:0]          mb_word_off;
  logic [MB_IDX_W-1:0] mb_idx;
  logic                err_cond;
  logic                err_now;
  logic                wr_ok, rd_ok;
  logic                ctrl_wr, done_wr, mb_wr, rx_pop, rx_ovf_clr;

  // ---------------- Register state ----------------
  logic [CTRL_W-1:0]    ctrl;
  logic [NUM_TX_MB-1:0] mb_pending;
  logic [NUM_TX_MB-1:0] tx_done;
  logic [FRAME_W-1:0]   mb [NUM_TX_MB];
  logic [NUM_TX_MB-1:0] pend_set, pend_clr;

  // ---------------- Arbiter state ----------------
  tx_state_t           tx_state;
  logic [MB_IDX_W-1:0] rr_ptr;
  logic [MB_IDX_W-1:0] grant;
  logic [MB_IDX_W-1:0] grant_nxt;
  logic                grant_found;
  logic                tx_accept;

  // ---------------- RX FIFO ----------------
  logic [FRAME_W-1:0] rx_head;
  logic               rx_full, rx_empty, rx_ovf;
  logic [CNT_W-1:0]   rx_count;

  logic [31:0] status;
  logic [31:0] rd_mux;

  // Mailbox index offset from base, wrapping at NUM_TX_MB
  function automatic logic [MB_IDX_W-1:0] wrap_idx(input logic [MB_IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_TX_MB) sum = sum - NUM_TX_MB;
    return MB_IDX_W'(sum);
  endfunction

  assign addr_acc = HSEL & HREADYOUT & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

  // Register the address phase; the data phase is decoded from these copies
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_vld      <= 1'b0;
      dp_write    <= 1'b0;
      dp_size_ok  <= 1'b0;
      dp_align_ok <= 1'b0;
      dp_word     <= '0;
      err_ph2     <= 1'b0;
    end else begin
      dp_vld  <= addr_acc;
      err_ph2 <= err_now;
      if (addr_acc) begin
        dp_word     <= HADDR[7:2];
        dp_align_ok <= (HADDR[1:0] == 2'b00);
        dp_write    <= HWRITE;
        dp_size_ok  <= (HSIZE == HSIZE_WORD);
      end
    end
  end

  assign mb_word_off = dp_word - word_of(ADDR_MB_BASE);
  assign mb_idx      = mb_word_off[MB_IDX_W-1:0];
  assign sel_ctrl    = dp_align_ok && (dp_word == word_of(ADDR_CTRL));
  assign sel_status  = dp_align_ok && (dp_word == word_of(ADDR_STATUS));
  assign sel_rxdata  = dp_align_ok && (dp_word == word_of(ADDR_RXDATA));
  assign sel_done    = dp_align_ok && (dp_word == word_of(ADDR_DONE));
  assign sel_mb      = dp_align_ok && (dp_word >= word_of(ADDR_MB_BASE)) &&
                       (mb_word_off < 6'(NUM_TX_MB));

  // Error is judged against live state in the data phase so back-to-back writes see each other
  assign err_cond = !dp_size_ok
                  | !(sel_ctrl | sel_status | sel_rxdata | sel_done | sel_mb)
                  | ( dp_write & (sel_status | sel_rxdata))
                  | (!dp_write & sel_mb)
                  | ( dp_write & sel_mb & mb_pending[mb_idx])
                  | (!dp_write & sel_rxdata & rx_empty);

  assign err_now   = dp_vld & err_cond;
  assign HREADYOUT = ~err_now;
  assign HRESP     = err_now | err_ph2;

  assign wr_ok      = dp_vld &  dp_write & ~err_cond;
  assign rd_ok      = dp_vld & ~dp_write & ~err_cond;
  assign ctrl_wr    = wr_ok & sel_ctrl;
  assign done_wr    = wr_ok & sel_done;
  assign mb_wr      = wr_ok & sel_mb;
  assign rx_pop     = rd_ok & sel_rxdata;
  assign rx_ovf_clr = done_wr & HWDATA[DONE_RX_OVF_CLR];

  // Assemble STATUS and the read-data mux for the current data phase
  always_comb begin
    status                  = '0;
    status[NUM_TX_MB-1:0]   = mb_pending;
    status[ST_RX_EMPTY]     = rx_empty;
    status[ST_RX_FULL]      = rx_full;
    status[ST_RX_OVF]       = rx_ovf;
    status[31:ST_RX_COUNT_LSB] = 8'(rx_count);

    rd_mux = '0;
    if (sel_ctrl)   rd_mux[CTRL_W-1:0]    = ctrl;
    if (sel_status) rd_mux                = status;
    if (sel_rxdata) rd_mux                = 32'(rx_head);
    if (sel_done)   rd_mux[NUM_TX_MB-1:0] = tx_done;
  end

  assign HRDATA = rd_ok ? rd_mux : 32'h0;

  // One-hot pending set from a mailbox write and clear from an accepted offer
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (mb_wr)     pend_set[mb_idx] = 1'b1;
    if (tx_accept) pend_clr[grant]  = 1'b1;
  end

  // CTRL, mailbox frames, pending and done flags; a hardware done-set beats a W1C clear
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ctrl       <= '0;
      mb_pending <= '0;
      tx_done    <= '0;
      for (int i = 0; i < NUM_TX_MB; i++) mb[i] <= '0;
    end else begin
      if (ctrl_wr) ctrl <= HWDATA[CTRL_W-1:0];
      for (int i = 0; i < NUM_TX_MB; i++) begin
        if (mb_wr && (mb_idx == MB_IDX_W'(i))) mb[i] <= FRAME_W'(HWDATA);
      end
      mb_pending <= (mb_pending & ~pend_clr) | pend_set;
      tx_done    <= (done_wr ? (tx_done & ~HWDATA[NUM_TX_MB-1:0]) : tx_done) | pend_clr;
    end
  end

  // Round-robin search: first pending mailbox at or after rr_ptr
  always_comb begin
    grant_nxt   = '0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_TX_MB; i++) begin
      if (!grant_found && mb_pending[wrap_idx(rr_ptr, i)]) begin
        grant_nxt   = wrap_idx(rr_ptr, i);
        grant_found = 1'b1;
      end
    end
  end

  assign tx_accept = (tx_state == TX_OFFER) & tx_ready;

  // TX arbiter: an offer, once made, stays stable until accepted even if tx_en drops
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tx_state <= TX_IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (ctrl[CTRL_TX_EN] && grant_found) begin
            tx_state <= TX_OFFER;
            grant    <= grant_nxt;
            tx_valid <= 1'b1;
            tx_data  <= mb[grant_nxt];
          end
        end
        TX_OFFER: begin
          if (tx_ready) begin
            tx_state <= TX_IDLE;
            tx_valid <= 1'b0;
            rr_ptr   <= wrap_idx(grant, 1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Registered level interrupt
  always_ff @(posedge HCLK) begin
    if (HRESET) irq <= 1'b0;
    else irq <= (ctrl[CTRL_RX_IRQ_EN] & ~rx_empty)
              | (ctrl[CTRL_TX_IRQ_EN] & (|tx_done))
              | (ctrl[CTRL_RX_IRQ_EN] & rx_ovf);
  end

  can_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .W     (FRAME_W)
  ) u_rx_fifo (
    .clk     (HCLK),
    .rst     (HRESET),
    .push    (rx_valid),
    .din     (rx_data),
    .pop     (rx_pop),
    .ovf_clr (rx_ovf_clr),
    .dout    (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count),
    .ovf     (rx_ovf)
  );

endmodule

// File: tb/tb_ahb_can_mailbox.sv
// Directed bench for the AHB CAN mailbox: register access, TX arbitration, RX FIFO and errors.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Accepted TX frames are captured on the falling edge into a queue.
module tb_ahb_can_mailbox;
  import ahb_can_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [7:0]  HADDR = '0;
  logic [1:0]  HTRANS = HTRANS_IDLE;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = HSIZE_WORD;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = '0;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] txq[$];

  ahb_can_mailbox #(.NUM_TX_MB(4), .RX_DEPTH(8), .FRAME_W(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) begin
    if (!HRESET && tx_valid && tx_ready) txq.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // One AHB transfer; rsp = {HREADYOUT, HRESP} for data cycle 1 and for the final data cycle
  task automatic ahb_xfer(input logic wr, input logic [7:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, input logic dp_push, input logic [31:0] push_val,
                          output logic [31:0] rdata, output logic [3:0] rsp);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = wr; HADDR = addr; HSIZE = size;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HADDR = '0; HSIZE = HSIZE_WORD;
    HWDATA = wdata;
    if (dp_push) begin rx_valid = 1'b1; rx_data = push_val; end
    rdata  = HRDATA;
    rsp[3] = HREADYOUT;
    rsp[2] = HRESP;
    if (!HREADYOUT) begin
      @(posedge HCLK); #1;
      rx_valid = 1'b0;
    end
    rsp[1] = HREADYOUT;
    rsp[0] = HRESP;
    @(posedge HCLK); #1;
    rx_valid = 1'b0;
    HWDATA = '0;
  endtask

  task automatic ahb_wr(input string tag, input logic [7:0] addr, input logic [31:0] d);
    logic [31:0] rd;
    logic [3:0]  rsp;
    ahb_xfer(1'b1, addr, HSIZE_WORD, d, 1'b0, 32'h0, rd, rsp);
    chk({tag, "_rsp"}, 32'(rsp), 32'hA);
  endtask

  task automatic ahb_rd(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic [3:0]  rsp;
    ahb_xfer(1'b0, addr, HSIZE_WORD, 32'h0, 1'b0, 32'h0, rd, rsp);
    chk({tag, "_rsp"}, 32'(rsp), 32'hA);
    chk(tag, rd, exp);
  endtask

  task automatic ahb_err(input string tag, input logic wr, input logic [7:0] addr,
                         input logic [2:0] size, input logic [31:0] d);
    logic [31:0] rd;
    logic [3:0]  rsp;
    ahb_xfer(wr, addr, size, d, 1'b0, 32'h0, rd, rsp);
    chk(tag, 32'(rsp), 32'h7);
  endtask

  task automatic exp_tx(input string tag, input logic [31:0] exp);
    chk({tag, "_n"}, 32'(txq.size() > 0), 32'h1);
    if (txq.size() > 0) chk(tag, txq.pop_front(), exp);
  endtask

  task automatic push_frames(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = base + 32'(i);
      @(posedge HCLK); #1;
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  rsp;

    // Reset state
    cycles(3);
    HRESET = 1'b0;
    chk("rst_hready", 32'(HREADYOUT), 32'h1);
    chk("rst_hresp", 32'(HRESP), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_txvld", 32'(tx_valid), 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    ahb_rd("status_rst", ADDR_STATUS, 32'h0001_0000);

    // Two mailboxes sent back to back in index order
    tx_ready = 1'b1;
    ahb_wr("ctrl_txen", ADDR_CTRL, 32'h1);
    ahb_wr("mb1", 8'h14, 32'hA5A5_0001);
    ahb_wr("mb3", 8'h1C, 32'hA5A5_0003);
    cycles(4);
    exp_tx("tx_mb1", 32'hA5A5_0001);
    exp_tx("tx_mb3", 32'hA5A5_0003);
    ahb_rd("done_a", ADDR_DONE, 32'hA);
    ahb_rd("status_idle", ADDR_STATUS, 32'h0001_0000);
    ahb_wr("ctrl_txirq", ADDR_CTRL, 32'h5);
    cycles(1);
    chk("irq_tx", 32'(irq), 32'h1);
    ahb_wr("done_w1c", ADDR_DONE, 32'hF);
    cycles(1);
    chk("irq_tx_clr", 32'(irq), 32'h0);
    ahb_rd("done_clr", ADDR_DONE, 32'h0);
    ahb_wr("ctrl_txen2", ADDR_CTRL, 32'h1);

    // Offer held while the core stalls; a write to the pending mailbox errors
    tx_ready = 1'b0;
    ahb_wr("mb0", 8'h10, 32'h1111_0000);
    cycles(1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_vld", 32'(tx_valid), 32'h1);
      chk("hold_dat", tx_data, 32'h1111_0000);
      cycles(1);
    end
    ahb_err("mb0_busy_err", 1'b1, 8'h10, HSIZE_WORD, 32'hDEAD_BEEF);
    chk("hold_dat_err", tx_data, 32'h1111_0000);
    tx_ready = 1'b1;
    cycles(3);
    exp_tx("tx_mb0", 32'h1111_0000);
    chk("txvld_after", 32'(tx_valid), 32'h0);

    // Round-robin wrap: pointer sits at 1, so MB2 goes before MB0
    ahb_wr("ctrl_off", ADDR_CTRL, 32'h0);
    ahb_wr("mb0_b", 8'h10, 32'h0000_00B0);
    ahb_wr("mb2_b", 8'h18, 32'h0000_00B2);
    cycles(2);
    chk("txvld_disabled", 32'(tx_valid), 32'h0);
    ahb_wr("ctrl_on", ADDR_CTRL, 32'h1);
    cycles(6);
    exp_tx("rr_first", 32'h0000_00B2);
    exp_tx("rr_second", 32'h0000_00B0);
    ahb_rd("done_5", ADDR_DONE, 32'h5);

    // RX overflow: 9 frames into an 8-deep FIFO
    ahb_wr("ctrl_rxirq", ADDR_CTRL, 32'h3);
    push_frames(32'h0, 9);
    cycles(1);
    chk("irq_rx", 32'(irq), 32'h1);
    ahb_rd("status_ovf", ADDR_STATUS, 32'h0806_0000);
    for (int i = 0; i < 8; i++) ahb_rd("rx_drain", ADDR_RXDATA, 32'(i));
    ahb_err("rx_empty_err", 1'b0, ADDR_RXDATA, HSIZE_WORD, 32'h0);
    ahb_rd("status_empty_ovf", ADDR_STATUS, 32'h0005_0000);
    chk("irq_ovf", 32'(irq), 32'h1);
    ahb_wr("ovf_clr", ADDR_DONE, 32'h8000_0000);
    ahb_rd("status_ovf_clr", ADDR_STATUS, 32'h0001_0000);
    chk("irq_quiet", 32'(irq), 32'h0);

    // Full FIFO: a push coinciding with a pop is not an overflow
    push_frames(32'h10, 8);
    ahb_rd("status_full", ADDR_STATUS, 32'h0802_0000);
    ahb_xfer(1'b0, ADDR_RXDATA, HSIZE_WORD, 32'h0, 1'b1, 32'h18, rd, rsp);
    chk("coinc_rsp", 32'(rsp), 32'hA);
    chk("coinc_data", rd, 32'h10);
    ahb_rd("status_coinc", ADDR_STATUS, 32'h0802_0000);
    for (int i = 0; i < 8; i++) ahb_rd("rx_drain2", ADDR_RXDATA, 32'h11 + 32'(i));

    // Illegal accesses leave state alone
    ahb_err("hsize_err", 1'b1, ADDR_CTRL, 3'b000, 32'h7);
    ahb_rd("ctrl_kept", ADDR_CTRL, 32'h3);
    ahb_err("mb_read_err", 1'b0, 8'h10, HSIZE_WORD, 32'h0);
    ahb_err("status_wr_err", 1'b1, ADDR_STATUS, HSIZE_WORD, 32'h0);
    ahb_err("unmapped_err", 1'b1, 8'h20, HSIZE_WORD, 32'h0);
    ahb_err("misalign_err", 1'b0, 8'h06, HSIZE_WORD, 32'h0);

    // Reset during an offer drops tx_valid on the next cycle
    tx_ready = 1'b0;
    ahb_wr("mb2_rst", 8'h18, 32'h2222_0002);
    cycles(2);
    chk("offer_before_rst", 32'(tx_valid), 32'h1);
    HRESET = 1'b1;
    cycles(1);
    chk("offer_after_rst", 32'(tx_valid), 32'h0);
    chk("hready_in_rst", 32'(HREADYOUT), 32'h1);
    HRESET = 1'b0;
    cycles(1);
    ahb_rd("status_post_rst", ADDR_STATUS, 32'h0001_0000);
    ahb_rd("ctrl_post_rst", ADDR_CTRL, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
